// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and constants for the game-RAM arbiter.
//   state_e          - arbiter sequencer states
//   AW_DEF / DW_DEF  - default RAM address / data widths
//   REQ_DISP/REQ_GAME- requester ids (display scanout / snake engine)
package ram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    TURN,
    RWAIT,
    RESP
  } state_e;

  localparam int unsigned AW_DEF = 8;
  localparam int unsigned DW_DEF = 4;

  localparam logic REQ_DISP = 1'b0;
  localparam logic REQ_GAME = 1'b1;

endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: combinational two-way requester picker.
// Policy macro: RAM_ARB_RR_EN (defined = round-robin on ties,
// undefined = display requester always wins ties).
// Ports:
//   req0_i        display request
//   req1_i        game request
//   last_winner_i id of the requester that won the previous command
//   winner_o      id of the requester to serve
//   any_o         at least one request pending
module ram_arb_pick
  import ram_arb_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_winner_i,
  output logic winner_o,
  output logic any_o
);

  always_comb begin
    any_o = req0_i | req1_i;
`ifdef RAM_ARB_RR_EN
    if (req0_i && req1_i) begin
      winner_o = ~last_winner_i;
    end else begin
      winner_o = req1_i ? REQ_GAME : REQ_DISP;
    end
`else
    // Display wins whenever it asks; with no request at all the id simply
    // keeps pointing at the last winner (ignored because any_o is low).
    winner_o = ~req0_i & (req1_i | last_winner_i);
`endif
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: sequences the single-port game RAM between the display
// scanout reader (requester 0) and the snake engine (requester 1).
// One command at a time; owns the tri-state data bus; a turnaround cycle
// follows every write; read data returns with a one-cycle valid pulse.
// Optional macro: RAM_ARB_RR_EN selects round-robin tie-breaking.
// Ports:
//   clk_i, rst_i            clock, synchronous active-low reset
//   req0_i, addr0_i         display read request / address
//   gnt0_o, rvalid0_o       display grant / read-valid pulses
//   req1_i, we1_i, addr1_i, wdata1_i  game request, op, address, data
//   gnt1_o, rvalid1_o       game grant / read-valid pulses
//   rdata_o                 read data, valid with rvalid0_o/rvalid1_o
//   ram_wr_en_o, ram_rd_en_o, ram_addr_o, ram_data_io  RAM interface
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned AW     = AW_DEF,
  parameter int unsigned DW     = DW_DEF,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req0_i,
  input  logic [AW-1:0] addr0_i,
  output logic          gnt0_o,
  output logic          rvalid0_o,
  input  logic          req1_i,
  input  logic          we1_i,
  input  logic [AW-1:0] addr1_i,
  input  logic [DW-1:0] wdata1_i,
  output logic          gnt1_o,
  output logic          rvalid1_o,
  output logic [DW-1:0] rdata_o,
  output logic          ram_wr_en_o,
  output logic          ram_rd_en_o,
  output logic [AW-1:0] ram_addr_o,
  inout  logic [DW-1:0] ram_data_io
);

  localparam logic [1:0] CNT_LAST = 2'(RD_LAT - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic          we_q,    we_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          win_q,   win_d;
  logic          last_q,  last_d;
  logic [1:0]    cnt_q,   cnt_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic pick_win;
  logic pick_any;

  ram_arb_pick u_pick (
    .req0_i        (req0_i),
    .req1_i        (req1_i),
    .last_winner_i (last_q),
    .winner_o      (pick_win),
    .any_o         (pick_any)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      win_q   <= REQ_DISP;
      last_q  <= REQ_GAME;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      win_q   <= win_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    win_d       = win_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    gnt0_o      = 1'b0;
    gnt1_o      = 1'b0;
    rvalid0_o   = 1'b0;
    rvalid1_o   = 1'b0;
    ram_wr_en_o = 1'b0;
    ram_rd_en_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          win_d   = pick_win;
          addr_d  = (pick_win == REQ_GAME) ? addr1_i : addr0_i;
          // The display port is read-only, so its commands are never writes.
          we_d    = (pick_win == REQ_GAME) & we1_i;
          wdata_d = wdata1_i;
          state_d = CMD;
        end
      end
      CMD: begin
        ram_wr_en_o = we_q;
        ram_rd_en_o = ~we_q;
        gnt0_o      = (win_q == REQ_DISP);
        gnt1_o      = (win_q == REQ_GAME);
        last_d      = win_q;
        if (we_q) begin
          state_d = TURN;
        end else begin
          cnt_d   = '0;
          state_d = RWAIT;
        end
      end
      TURN: begin
        state_d = IDLE;
      end
      RWAIT: begin
        if (cnt_q == CNT_LAST) begin
          rdata_d = ram_data_io;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      RESP: begin
        rvalid0_o = (win_q == REQ_DISP);
        rvalid1_o = (win_q == REQ_GAME);
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ram_addr_o  = addr_q;
  assign rdata_o     = rdata_q;
  assign ram_data_io = ram_wr_en_o ? wdata_q : 'z;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed, table-driven bench for ram_arbiter with a
// behavioural 256x4 RAM (one-cycle read latency) on the shared bus.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req0, req1, we1;
  logic [7:0] addr0, addr1;
  logic [3:0] wdata1;
  logic       gnt0, rv0, gnt1, rv1, wr, rd;
  logic [7:0] raddr;
  logic [3:0] rdata;
  wire  logic [3:0] ram_data;

  ram_arbiter #(.AW(8), .DW(4), .RD_LAT(1)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req0_i      (req0),
    .addr0_i     (addr0),
    .gnt0_o      (gnt0),
    .rvalid0_o   (rv0),
    .req1_i      (req1),
    .we1_i       (we1),
    .addr1_i     (addr1),
    .wdata1_i    (wdata1),
    .gnt1_o      (gnt1),
    .rvalid1_o   (rv1),
    .rdata_o     (rdata),
    .ram_wr_en_o (wr),
    .ram_rd_en_o (rd),
    .ram_addr_o  (raddr),
    .ram_data_io (ram_data)
  );

  // RAM model: write samples the bus at the strobe edge, read data is
  // driven during the cycle after ram_rd_en_o.
  logic [3:0] mem [256];
  logic [3:0] rq = 4'h0;
  logic       oe = 1'b0;
  always @(posedge clk) begin
    if (wr) mem[raddr] <= ram_data;
    oe <= rd;
    if (rd) rq <= mem[raddr];
  end
  assign ram_data = oe ? rq : 4'bzzzz;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_hiz(input string name);
    checks++;
    if (!(ram_data === 4'bzzzz || ram_data === 4'b0000)) begin
      errors++;
      $display("FAIL %s bus got %h expected high-Z", name, ram_data);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if ((wr && rd) || (gnt0 && gnt1)) begin
        errors++;
        $display("FAIL excl wr=%b rd=%b gnt0=%b gnt1=%b expected no overlap", wr, rd, gnt0, gnt1);
      end
    end
  end

  typedef struct {
    logic       rst;
    logic       r0;
    logic [7:0] a0;
    logic       r1;
    logic       we;
    logic [7:0] a1;
    logic [3:0] wd;
    logic [5:0] outs;  // {gnt0,gnt1,rv0,rv1,wr,rd}
    logic [7:0] ea;
    logic [3:0] erd;
    logic [1:0] bm;    // 0 no bus check, 1 expect ebus, 2 expect high-Z
    logic [3:0] eb;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rs, input logic r0, input logic [7:0] a0,
                              input logic r1, input logic we, input logic [7:0] a1,
                              input logic [3:0] wd, input logic [5:0] outs,
                              input logic [7:0] ea, input logic [3:0] erd,
                              input logic [1:0] bm, input logic [3:0] eb);
    vec_t v;
    v.rst = rs; v.r0 = r0; v.a0 = a0; v.r1 = r1; v.we = we; v.a1 = a1; v.wd = wd;
    v.outs = outs; v.ea = ea; v.erd = erd; v.bm = bm; v.eb = eb;
    return v;
  endfunction

  initial begin
    logic [5:0] exp_order;
    logic       seen;
    int         n;

    for (int i = 0; i < 256; i++) mem[i] = 4'h0;

    // reset, game write 3<-1
    tbl.push_back(mk(0,0,  0,0,0,  0, 0,6'b000000,  0, 0,2,0));
    tbl.push_back(mk(1,0,  0,1,1,  3, 1,6'b000000,  0, 0,2,0));
    tbl.push_back(mk(1,0,  0,0,0,  0, 0,6'b010010,  3, 0,1,1));
    tbl.push_back(mk(1,0,  0,0,0,  0, 0,6'b000000,  3, 0,2,0));
    // write 255<-15, read it back
    tbl.push_back(mk(1,0,  0,1,1,255,15,6'b000000,  3, 0,2,0));
    tbl.push_back(mk(1,0,  0,0,0,  0, 0,6'b010010,255, 0,1,15));
    tbl.push_back(mk(1,0,  0,0,0,  0, 0,6'b000000,255, 0,2,0));
    tbl.push_back(mk(1,0,  0,1,0,255, 0,6'b000000,255, 0,2,0));
    tbl.push_back(mk(1,0,  0,0,0,  0, 0,6'b010001,255, 0,0,0));
    tbl.push_back(mk(1,0,  0,0,0,  0, 0,6'b000000,255, 0,0,0));
    tbl.push_back(mk(1,0,  0,0,0,  0, 0,6'b000100,255,15,2,0));
    // preload 63<-7, 15<-3
    tbl.push_back(mk(1,0,  0,1,1, 63, 7,6'b000000,255,15,2,0));
    tbl.push_back(mk(1,0,  0,0,0,  0, 0,6'b010010, 63,15,1,7));
    tbl.push_back(mk(1,0,  0,0,0,  0, 0,6'b000000, 63,15,2,0));
    tbl.push_back(mk(1,0,  0,1,1, 15, 3,6'b000000, 63,15,2,0));
    tbl.push_back(mk(1,0,  0,0,0,  0, 0,6'b010010, 15,15,1,3));
    tbl.push_back(mk(1,0,  0,0,0,  0, 0,6'b000000, 15,15,2,0));
    // contention: display wins, game served in the next slot
    tbl.push_back(mk(1,1, 63,1,0, 15, 0,6'b000000, 15,15,2,0));
    tbl.push_back(mk(1,0,  0,1,0, 15, 0,6'b100001, 63,15,0,0));
    tbl.push_back(mk(1,0,  0,1,0, 15, 0,6'b000000, 63,15,0,0));
    tbl.push_back(mk(1,0,  0,1,0, 15, 0,6'b001000, 63, 7,2,0));
    tbl.push_back(mk(1,0,  0,1,0, 15, 0,6'b000000, 63, 7,2,0));
    tbl.push_back(mk(1,0,  0,0,0,  0, 0,6'b010001, 15, 7,0,0));
    tbl.push_back(mk(1,0,  0,0,0,  0, 0,6'b000000, 15, 7,0,0));
    tbl.push_back(mk(1,0,  0,0,0,  0, 0,6'b000100, 15, 3,2,0));
    // game write 10<-9 then immediately read 10
    tbl.push_back(mk(1,0,  0,1,1, 10, 9,6'b000000, 15, 3,2,0));
    tbl.push_back(mk(1,0,  0,1,0, 10, 0,6'b010010, 10, 3,1,9));
    tbl.push_back(mk(1,0,  0,1,0, 10, 0,6'b000000, 10, 3,2,0));
    tbl.push_back(mk(1,0,  0,1,0, 10, 0,6'b000000, 10, 3,2,0));
    tbl.push_back(mk(1,0,  0,0,0,  0, 0,6'b010001, 10, 3,0,0));
    tbl.push_back(mk(1,0,  0,0,0,  0, 0,6'b000000, 10, 3,0,0));
    tbl.push_back(mk(1,0,  0,0,0,  0, 0,6'b000100, 10, 9,2,0));
    tbl.push_back(mk(1,0,  0,0,0,  0, 0,6'b000000, 10, 9,2,0));

    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata1 = '0;
    repeat (3) @(posedge clk);
    mon_en = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      rst = tbl[i].rst; req0 = tbl[i].r0; addr0 = tbl[i].a0;
      req1 = tbl[i].r1; we1 = tbl[i].we; addr1 = tbl[i].a1; wdata1 = tbl[i].wd;
      @(negedge clk);
      check($sformatf("row%0d", i), {14'd0, gnt0, gnt1, rv0, rv1, wr, rd, raddr, rdata},
            {14'd0, tbl[i].outs, tbl[i].ea, tbl[i].erd});
      if (tbl[i].bm == 2'd1) check($sformatf("row%0d_bus", i), {28'd0, ram_data}, {28'd0, tbl[i].eb});
      if (tbl[i].bm == 2'd2) check_hiz($sformatf("row%0d_hiz", i));
    end

    // reset in the middle of a read
    @(posedge clk); #1; req1 = 1'b1; we1 = 1'b0; addr1 = 8'd255;
    @(posedge clk); #1; req1 = 1'b0;
    @(negedge clk); check("rm_gnt", {31'd0, gnt1}, 32'd1);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    check("rm_outs", {26'd0, gnt0, gnt1, rv0, rv1, wr, rd}, 32'd0);
    check("rm_addr", {24'd0, raddr}, 32'd0);
    check("rm_rdata", {28'd0, rdata}, 32'd0);
    check_hiz("rm_hiz");
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rv0 || rv1 || gnt0 || gnt1) seen = 1'b1;
    end
    check("rm_quiet", {31'd0, seen}, 32'd0);

    // both requesters held: grant order depends on tie policy
`ifdef RAM_ARB_RR_EN
    exp_order = 6'b101010;
`else
    exp_order = 6'b000000;
`endif
    @(negedge clk);
    req0 = 1'b1; addr0 = 8'd63; req1 = 1'b1; we1 = 1'b0; addr1 = 8'd15;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      @(negedge clk);
      while (!(gnt0 || gnt1) && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) begin
        checks++; errors++;
        $display("FAIL order%0d no grant within 20 cycles, expected a grant", k);
      end else begin
        check($sformatf("order%0d", k), {31'd0, gnt1}, {31'd0, exp_order[k]});
      end
    end
    req0 = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(gnt0 || gnt1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL late_gnt1 no grant within 20 cycles, expected gnt1");
    end else begin
      check("late_gnt1", {30'd0, gnt0, gnt1}, 32'd1);
    end
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    check("late_rdata", {27'd0, rv1, rdata}, {27'd0, 1'b1, 4'd3});
    repeat (4) @(negedge clk);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
